// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Divider table, widths and FSM states shared by note player
//               and display decoder.
// Revision    : 1.0
// ============================================================================
package note_pkg;

    localparam int NOTE_DIV_W = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [NOTE_DIV_W-1:0] NOTE_DIV_LO [1:7] = '{
        22'd191570, 22'd170648, 22'd151515, 22'd143266,
        22'd127551, 22'd113636, 22'd101215
    };

    localparam logic [NOTE_DIV_W-1:0] NOTE_DIV_HI [1:7] = '{
        22'd95420, 22'd85034, 22'd75758, 22'd71633,
        22'd63776, 22'd56818, 22'd50607
    };

    // Code 0 is a rest and maps to the silent divider in either octave.
    function automatic logic [NOTE_DIV_W-1:0] note_div_lookup(
        input logic [2:0] code,
        input logic       oct
    );
        logic [NOTE_DIV_W-1:0] div;
        div = '0;
        if (code != 3'd0) begin
            div = oct ? NOTE_DIV_HI[int'(code)] : NOTE_DIV_LO[int'(code)];
        end
        return div;
    endfunction

endpackage : note_pkg
`default_nettype wire

// File: rtl/note_player_square_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : square_wave_gen
// Description : Half-period counter toggling a square wave every div cycles.
// Revision    : 1.0
// ============================================================================
module square_wave_gen
    import note_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [NOTE_DIV_W-1:0] div,
    output logic                  wave
);

    localparam logic [NOTE_DIV_W-1:0] ONE = NOTE_DIV_W'(1);

    logic [NOTE_DIV_W-1:0] tc_q;
    logic                  wave_q;

    // A zero divider means silence: counter and output are parked at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc_q   <= '0;
            wave_q <= 1'b0;
        end else if (clr || (div == '0)) begin
            tc_q   <= '0;
            wave_q <= 1'b0;
        end else if (tc_q == (div - ONE)) begin
            tc_q   <= '0;
            wave_q <= ~wave_q;
        end else begin
            tc_q   <= tc_q + ONE;
        end
    end

    assign wave = wave_q;

endmodule : square_wave_gen
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module      : note_player
// Description : Accepts a note request, plays it for DUR_CYCLES, then stays
//               silent for GAP_CYCLES before accepting the next one.
// Revision    : 1.0
// ============================================================================
module note_player
    import note_pkg::*;
#(
    parameter int DUR_CYCLES = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic [2:0]            note_code,
    input  logic                  octave,
    output logic [NOTE_DIV_W-1:0] note_div,
    output logic                  audio_out,
    output logic                  busy
);

    localparam int CNT_MAX = (DUR_CYCLES > GAP_CYCLES) ? DUR_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DUR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NOTE_DIV_W-1:0] note_div_q;
    logic                  accept;
    logic                  play_done;

    assign note_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign accept     = note_valid && note_ready;
    assign play_done  = (state_q == PLAY) && (cnt_q == DUR_LAST);

    // The divider is latched at acceptance so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            note_div_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= PLAY;
                        cnt_q      <= '0;
                        note_div_q <= note_div_lookup(note_code, octave);
                    end
                end
                PLAY: begin
                    if (cnt_q == DUR_LAST) begin
                        cnt_q      <= '0;
                        note_div_q <= '0;
                        state_q    <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    note_div_q <= '0;
                end
            endcase
        end
    end

    assign note_div = note_div_q;

    // Clearing on both entry and exit of PLAY restarts the phase and forces
    // the wave low even when the note ends mid-period.
    square_wave_gen u_wave (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept || play_done),
        .div   (note_div_q),
        .wave  (audio_out)
    );

endmodule : note_player
`default_nettype wire
